// File: rtl/vctr_fetch_pkg.sv
// vctr_fetch_pkg: shared FSM state type and constants for the vector fetch engine
package vctr_fetch_pkg;
  typedef enum logic [1:0] {IDLE, POP, ISSUE, DRAIN} state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  function automatic int pend_w(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction
endpackage

// File: rtl/vctr_fetch_rsp.sv
// vctr_fetch_rsp: registers read responses into the vector FIFO and tracks reads in flight
module vctr_fetch_rsp
  import vctr_fetch_pkg::*;
#(
  parameter int PW = pend_w(4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept,
  input  logic          master_data_in_val,
  input  logic [31:0]   master_data_in,
  output logic [31:0]   vctr_fifo_din,
  output logic          vctr_fifo_wr,
  output logic [PW-1:0] pending,
  output logic          rsp_done
);
  logic take;
  // a response with nothing in flight is a leftover from before reset
  assign take = master_data_in_val && pending != '0;
  assign rsp_done = pending == '0;
  always_ff @(posedge clk)
    if (reset) begin
      pending <= '0;
      vctr_fifo_din <= '0;
      vctr_fifo_wr <= 1'b0;
    end else begin
      pending <= pending + PW'(accept) - PW'(take);
      vctr_fifo_wr <= take;
      if (take) vctr_fifo_din <= master_data_in;
    end
endmodule

// File: rtl/vctr_fetch.sv
// vctr_fetch: pops vector base addresses, reads WORDS_PER_VECTOR words each, pushes them to the vector FIFO
// Optional VCTR_FETCH_ALIGN_CHK_EN: misaligned bases set sticky err and are skipped
module vctr_fetch
  import vctr_fetch_pkg::*;
#(
  parameter int WORDS_PER_VECTOR = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_program,
  input  logic [31:0] addr_fifo_dout,
  input  logic        addr_fifo_empty,
  output logic        addr_fifo_rd,
  output logic [31:0] master_addr,
  output logic        master_rd,
  input  logic        master_waitrequest,
  input  logic [31:0] master_data_in,
  input  logic        master_data_in_val,
  output logic [31:0] vctr_fifo_din,
  output logic        vctr_fifo_wr,
  input  logic [15:0] vctr_fifo_space,
  output logic        busy,
  output logic [15:0] vectors_fetched,
  output logic        err
);
  localparam int PW = pend_w(MAX_OUTSTANDING);
  state_t state, state_n;
  logic [31:0] base;
  logic [7:0] idx;
  logic [PW-1:0] pending;
  logic rsp_done, accept, last, start, misaligned;
  vctr_fetch_rsp #(.PW(PW)) u_rsp (
    .clk(clk),
    .reset(reset),
    .accept(accept),
    .master_data_in_val(master_data_in_val),
    .master_data_in(master_data_in),
    .vctr_fifo_din(vctr_fifo_din),
    .vctr_fifo_wr(vctr_fifo_wr),
    .pending(pending),
    .rsp_done(rsp_done)
  );
  assign start = run_program && !addr_fifo_empty &&
                 int'(vctr_fifo_space) >= WORDS_PER_VECTOR + int'(pending);
  assign addr_fifo_rd = state == POP;
  assign master_rd = state == ISSUE && int'(pending) < MAX_OUTSTANDING;
  assign accept = master_rd && !master_waitrequest;
  assign last = idx == 8'(WORDS_PER_VECTOR - 1);
  assign master_addr = base + 32'(idx) * WORD_BYTES;
  assign busy = state != IDLE || !rsp_done;
  always_comb
    state_n = state == IDLE  ? (start ? POP : IDLE) :
              state == POP   ? (misaligned ? IDLE : ISSUE) :
              state == ISSUE ? (accept && last ? DRAIN : ISSUE) :
                               (rsp_done ? IDLE : DRAIN);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      base <= '0;
      idx <= '0;
      vectors_fetched <= '0;
    end else begin
      state <= state_n;
      if (state == POP) begin
        base <= addr_fifo_dout & ~(WORD_BYTES - 32'd1);
        idx <= '0;
      end else if (accept) idx <= idx + 8'd1;
      if (state == DRAIN && rsp_done) vectors_fetched <= vectors_fetched + 16'd1;
    end
`ifdef VCTR_FETCH_ALIGN_CHK_EN
  assign misaligned = addr_fifo_dout[1:0] != 2'b00;
  always_ff @(posedge clk)
    if (reset) err <= 1'b0;
    else if (state == POP && misaligned) err <= 1'b1;
`else
  assign misaligned = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_vctr_fetch.sv
// tb_vctr_fetch: randomized scoreboard bench for vctr_fetch with a queue-based reference model
module tb_vctr_fetch;
  localparam int W = 4;
  localparam int M = 2;
`ifdef VCTR_FETCH_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, run_program, addr_fifo_empty, addr_fifo_rd, master_rd, master_waitrequest;
  logic master_data_in_val, vctr_fifo_wr, busy, err;
  logic [31:0] addr_fifo_dout, master_addr, master_data_in, vctr_fifo_din;
  logic [15:0] vctr_fifo_space, vectors_fetched;
  typedef struct {int due; logic [31:0] data; bit stale;} rsp_t;
  logic [31:0] af_q[$], exp_addr[$], exp_data[$];
  rsp_t rq[$];
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, wr_cnt = 0, pop_cnt = 0, stall_cnt = 0, outst = 0;
  int lat_min = 2, lat_max = 2, wait_pct = 0, wait_hold = 0, exp_vec = 0;
  logic exp_err = 1'b0;
  bit rd_seen = 1'b0;

  vctr_fetch #(.WORDS_PER_VECTOR(W), .MAX_OUTSTANDING(M)) dut (
    .clk(clk), .reset(reset), .run_program(run_program),
    .addr_fifo_dout(addr_fifo_dout), .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd(addr_fifo_rd),
    .master_addr(master_addr), .master_rd(master_rd), .master_waitrequest(master_waitrequest),
    .master_data_in(master_data_in), .master_data_in_val(master_data_in_val),
    .vctr_fifo_din(vctr_fifo_din), .vctr_fifo_wr(vctr_fifo_wr), .vctr_fifo_space(vctr_fifo_space),
    .busy(busy), .vectors_fetched(vectors_fetched), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm, input logic [31:0] v);
    checks++;
    errors++;
    $display("FAIL %s: value %h", nm, v);
  endtask

  // reference model: a vector is WORDS consecutive word reads from the word-aligned base
  task automatic push_vec(input logic [31:0] a);
    logic [31:0] b;
    af_q.push_back(a);
    if (ALIGN && a[1:0] != 2'b00) exp_err = 1'b1;
    else begin
      b = a & ~32'd3;
      for (int i = 0; i < W; i++) begin
        exp_addr.push_back(b + 32'(4 * i));
        exp_data.push_back(mem(b + 32'(4 * i)));
      end
      exp_vec++;
    end
  endtask

  task automatic rst_checks();
    chk("reset addr_fifo_rd", addr_fifo_rd, 0);
    chk("reset master_rd", master_rd, 0);
    chk("reset master_addr", master_addr, 0);
    chk("reset vctr_fifo_din", vctr_fifo_din, 0);
    chk("reset vctr_fifo_wr", vctr_fifo_wr, 0);
    chk("reset busy", busy, 0);
    chk("reset vectors_fetched", vectors_fetched, 0);
    chk("reset err", err, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((af_q.size() != 0 || busy || exp_data.size() != 0 || rq.size() != 0) && t < 3000);
    if (t >= 3000) note_fail("idle timeout", 32'(exp_data.size()));
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (acc_cnt < n) note_fail("accept timeout", 32'(acc_cnt));
  endtask

  // bus slave, address FIFO and output monitor, stepping 1 time unit after each clock edge
  initial begin
    addr_fifo_empty = 1'b1;
    addr_fifo_dout = '0;
    master_waitrequest = 1'b0;
    master_data_in = '0;
    master_data_in_val = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rd_seen && af_q.size() != 0) void'(af_q.pop_front());
      rd_seen = addr_fifo_rd;
      if (addr_fifo_rd) pop_cnt++;
      addr_fifo_empty = af_q.size() == 0;
      addr_fifo_dout = af_q.size() != 0 ? af_q[0] : 32'd0;
      if (vctr_fifo_wr) begin
        wr_cnt++;
        if (exp_data.size() == 0) note_fail("unexpected push", vctr_fifo_din);
        else chk("push data", vctr_fifo_din, exp_data.pop_front());
      end
      master_waitrequest = wait_hold > 0 || $urandom_range(99) < wait_pct;
      if (wait_hold > 0) wait_hold--;
      if (master_rd && master_waitrequest) begin
        stall_cnt++;
        if (exp_addr.size() != 0) chk("stalled addr", master_addr, exp_addr[0]);
      end
      if (master_rd && !master_waitrequest) begin
        acc_cnt++;
        chk("in-flight limit", 32'(outst < M), 1);
        if (exp_addr.size() == 0) note_fail("unexpected read", master_addr);
        else chk("read addr", master_addr, exp_addr.pop_front());
        rq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), mem(master_addr), 1'b0});
        outst++;
      end
      if (rq.size() != 0 && rq[0].due <= cyc) begin
        master_data_in_val = 1'b1;
        master_data_in = rq[0].data;
        if (!rq[0].stale) outst--;
        void'(rq.pop_front());
      end else begin
        master_data_in_val = 1'b0;
        master_data_in = $urandom;
      end
    end
  end

  initial begin
    logic [11:0] rdv;
    logic [31:0] a;
    int b, p, t;
    reset = 1'b1;
    run_program = 1'b0;
    vctr_fifo_space = 16'd64;
    repeat (3) @(negedge clk);
    rst_checks();
    reset = 1'b0;
    run_program = 1'b1;
    push_vec(32'h1000);
    wait_idle();
    chk("single vectors_fetched", vectors_fetched, 16'(exp_vec));
    chk("single busy", busy, 0);
    b = acc_cnt;
    p = stall_cnt;
    push_vec(32'h1000);
    wait_acc(b + 1);
    wait_hold = 3;
    wait_idle();
    chk("waitrequest stall cycles", stall_cnt - p, 3);
    chk("waitrequest vectors_fetched", vectors_fetched, 16'(exp_vec));
    vctr_fifo_space = 16'd3;
    p = pop_cnt;
    push_vec(32'h3000);
    repeat (10) @(negedge clk);
    chk("backpressure no pop", pop_cnt - p, 0);
    vctr_fifo_space = 16'd4;
    @(negedge clk);
    chk("backpressure pop", addr_fifo_rd, 1);
    wait_idle();
    vctr_fifo_space = 16'd64;
    lat_min = 10;
    lat_max = 10;
    push_vec(32'h4000);
    t = 0;
    while (!addr_fifo_rd && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!addr_fifo_rd) note_fail("pop timeout", 32'(t));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdv[i] = master_rd;
    end
    chk("outstanding rd pattern", 32'(rdv), 32'h803);
    wait_idle();
    b = acc_cnt;
    push_vec(32'h5000);
    wait_acc(b + 2);
    @(negedge clk);
    reset = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    foreach (rq[i]) rq[i].stale = 1'b1;
    outst = 0;
    exp_vec = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_checks();
    reset = 1'b0;
    p = wr_cnt;
    repeat (15) @(negedge clk);
    chk("late responses dropped", wr_cnt - p, 0);
    chk("post-reset vectors_fetched", vectors_fetched, 0);
    lat_min = 2;
    lat_max = 2;
    push_vec(32'h1002);
    push_vec(32'h2000);
    wait_idle();
    chk("align err", err, 32'(exp_err));
    chk("align vectors_fetched", vectors_fetched, 16'(exp_vec));
    lat_min = 1;
    lat_max = 6;
    wait_pct = 25;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      push_vec(a);
      repeat ($urandom_range(6)) begin
        @(negedge clk);
        run_program = $urandom_range(3) != 0;
        vctr_fifo_space = 16'($urandom_range(10));
      end
    end
    run_program = 1'b1;
    vctr_fifo_space = 16'd64;
    wait_idle();
    chk("random vectors_fetched", vectors_fetched, 16'(exp_vec));
    chk("random err", err, 32'(exp_err));
    chk("random busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vctr_fetch.md
# vctr_fetch

Vector fetch engine: the consumer end of the address FIFO that the driver control logic fills. It pops test-vector base addresses, issues word reads on the master bus, and pushes the returned data words into the vector FIFO, where the driver monitor counts them via `vctr_fifo_wr`. It sits between the address FIFO, the master memory port and the vector FIFO.

## Interface
- `WORDS_PER_VECTOR`, default 4: data words fetched per popped address; range 1..255.
- `MAX_OUTSTANDING`, default 4: maximum reads in flight; range 1..15.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `run_program` in 1: fetch enable.
- `addr_fifo_dout` in 32: head of the address FIFO. The FIFO is first-word-fall-through, so the head is valid whenever the FIFO is not empty.
- `addr_fifo_empty` in 1: address FIFO empty.
- `addr_fifo_rd` out 1: pop strobe, one cycle per address.
- `master_addr` out 32: read byte address.
- `master_rd` out 1: read request.
- `master_waitrequest` in 1: slave stall; request is held while high.
- `master_data_in` in 32: read data.
- `master_data_in_val` in 1: read data valid; responses arrive in order.
- `vctr_fifo_din` out 32: vector data word.
- `vctr_fifo_wr` out 1: vector FIFO push.
- `vctr_fifo_space` in 16: free words in the vector FIFO.
- `busy` out 1: FSM not in IDLE, or reads outstanding.
- `vectors_fetched` out 16: count of completed vectors; wraps.
- `err` out 1: sticky error flag (see Configuration).

## Operation
- FSM states:
  - IDLE: leave when `run_program` && !`addr_fifo_empty` && `vctr_fifo_space` >= `WORDS_PER_VECTOR` + words already pending; go to POP.
  - POP: `addr_fifo_rd`=1 for exactly one cycle; latch `addr_fifo_dout` into base; word index := 0; go to ISSUE.
  - ISSUE: drive `master_rd`=1 with `master_addr` = base + 4*index. Index advances only on `master_rd` && !`master_waitrequest`. If the pending count equals `MAX_OUTSTANDING`, deassert `master_rd` and hold. After the last word is accepted, go to DRAIN.
  - DRAIN: wait until every response for this vector is received. Increment `vectors_fetched`, then go to IDLE.
- Response path:
  - Each `master_data_in_val` is registered into `vctr_fifo_din`, with `vctr_fifo_wr`=1 on the next cycle.
  - The pending count increments on each accepted request and decrements on each response; a simultaneous accept and response leaves it unchanged.
  - A `master_data_in_val` that arrives while the pending count is 0 (stale after reset) is dropped: no push, no count change.
- Space check:
  - A vector starts only when the full vector fits in the vector FIFO, so overflow is impossible.
  - `vctr_fifo_space` is sampled only in IDLE.
- Stop:
  - `run_program` falling mid-vector does not abort; the current vector completes, then the FSM stays in IDLE.
- Address arithmetic:
  - 32-bit modulo add; wrap past 0xFFFFFFFC is permitted and unflagged.
- Reset:
  - All outputs are 0: `addr_fifo_rd`, `master_rd`, `master_addr`, `vctr_fifo_din`, `vctr_fifo_wr`, `busy`, `vectors_fetched`, `err`.
  - FSM goes to IDLE and the pending count to 0.
  - Reset mid-burst abandons the vector with no partial-vector completion; partial words already pushed remain in the FIFO.

## Timing
- Pop to first request: `addr_fifo_rd` in cycle N, `master_rd` asserted in cycle N+1.
- With zero waitrequest: one request per cycle until `MAX_OUTSTANDING` is reached.
- Response to push: one cycle, from `master_data_in_val` in cycle M to `vctr_fifo_wr` in cycle M+1.
- `vectors_fetched` updates in the cycle after the last response is registered.
- Minimum IDLE dwell between vectors: 1 cycle.

## Configuration
- `VCTR_FETCH_ALIGN_CHK_EN` defined:
  - In POP, a base address with bits [1:0] != 0 sets `err` (sticky until reset).
  - The vector is skipped: no reads are issued and `vectors_fetched` is unchanged.
  - The FSM returns to IDLE.
- Undefined:
  - Bits [1:0] of the base are forced to 00.
  - `err` is tied to 0.

## Structure
- Package `vctr_fetch_pkg`:
  - FSM state enum (IDLE, POP, ISSUE, DRAIN).
  - `WORD_BYTES`=4.
  - Pending-counter width constant, log2(`MAX_OUTSTANDING`)+1.
- Sub-module `vctr_fetch_rsp`:
  - Response capture register and pending-read counter, including the stale-response drop.
  - Provides `pending` and `rsp_done` to the FSM.

## Test plan
- Single vector:
  - Stimulus: address 0x1000, `WORDS_PER_VECTOR`=4, no waitrequest, responses 2 cycles after each request.
  - Required: reads at 0x1000, 0x1004, 0x1008 and 0x100C; 4 pushes in order; `vectors_fetched`=1; `busy` low afterwards.
- Waitrequest:
  - Stimulus: waitrequest held high for 3 cycles on the second read.
  - Required: `master_addr` holds 0x1004 stable; no address is skipped or duplicated.
- Backpressure:
  - Stimulus: `vctr_fifo_space`=3 with the address FIFO non-empty.
  - Required: no pop.
  - Stimulus: raise `vctr_fifo_space` to 4.
  - Required: pop within 1 cycle.
- Outstanding limit:
  - Stimulus: `MAX_OUTSTANDING`=2, responses delayed 10 cycles.
  - Required: `master_rd` drops after 2 accepted reads and resumes 1 cycle after the first response.
- Reset mid-burst:
  - Stimulus: reset after 2 reads accepted, then 2 late responses.
  - Required: outputs 0; late responses are dropped with no `vctr_fifo_wr`.
- With `VCTR_FETCH_ALIGN_CHK_EN`:
  - Stimulus: address 0x1002 followed by 0x2000.
  - Required: `err`=1; no reads for 0x1002; the 0x2000 vector is fetched normally; `vectors_fetched`=1.
